// File: rtl/serial_word_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial word adder sequencer.
package serial_word_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int word_width(input int nibbles);
    return NIBBLE_W * nibbles;
  endfunction

endpackage

// File: rtl/serial_word_adder_ctrl_if.sv
// Operand-in / result-out handshake bundle of the serial word adder sequencer.
interface serial_word_adder_ctrl_if
  import serial_word_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int W = word_width(NIBBLES);

  logic         InValid;
  logic         InReady;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         CinIn;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic         CoutOut;
  logic         Overflow;
  logic         Busy;

  modport master (
    output InValid, X, Y, CinIn, OutReady,
    input  InReady, OutValid, Result, CoutOut, Overflow, Busy
  );

  modport slave (
    input  InValid, X, Y, CinIn, OutReady,
    output InReady, OutValid, Result, CoutOut, Overflow, Busy
  );

endinterface

// File: rtl/ripple_carry_adder4.sv
// Purely combinational 4-bit ripple-carry adder driven by the sequencer.
module ripple_carry_adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic carry_s;

  // Bit-serial carry chain.
  always_comb begin
    carry_s = Cin;
    Sum     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      Sum[i]  = A[i] ^ B[i] ^ carry_s;
      carry_s = (A[i] & B[i]) | (carry_s & (A[i] ^ B[i]));
    end
    Cout = carry_s;
  end

endmodule

// File: rtl/serial_word_adder_ctrl.sv
// Feeds a word-wide operand pair nibble by nibble (LSB first) through an external
// 4-bit adder, chaining the carry, and hands the assembled sum downstream.
module serial_word_adder_ctrl
  import serial_word_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_word_adder_ctrl_if.slave   bus,
  output logic [NIBBLE_W-1:0]       AddA,
  output logic [NIBBLE_W-1:0]       AddB,
  output logic                      AddCin,
  input  logic [NIBBLE_W-1:0]       AddSum,
  input  logic                      AddCout
);

  localparam int W     = word_width(NIBBLES);
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W+1:0] base_s;

  assign base_s = {idx_q, 2'b00};

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.InValid) begin
          x_d     = bus.X;
          y_d     = bus.Y;
          carry_d = bus.CinIn;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d[base_s +: NIBBLE_W] = AddSum;
        carry_d = AddCout;
        // Sign of the top nibble's sum decides overflow against the operand signs.
        if (idx_q == LAST_IDX) begin
          cout_d  = AddCout;
          ovf_d   = (x_q[W-1] == y_q[W-1]) && (AddSum[3] != x_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (bus.OutReady) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Adder operands are only live while sequencing.
  always_comb begin
    if (state_q == S_RUN) begin
      AddA   = x_q[base_s +: NIBBLE_W];
      AddB   = y_q[base_s +: NIBBLE_W];
      AddCin = carry_q;
    end else begin
      AddA   = 4'd0;
      AddB   = 4'd0;
      AddCin = 1'b0;
    end
  end

  assign bus.InReady  = (state_q == S_IDLE) && !rst;
  assign bus.OutValid = (state_q == S_DONE);
  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.Result   = result_q;
  assign bus.CoutOut  = cout_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_serial_word_adder_ctrl.sv
// Bench for serial_word_adder_ctrl at NIBBLES = 4, 2 and 8, each paired with the 4-bit adder.
module tb_serial_word_adder_ctrl;

  logic        clk;
  logic        rst;
  int          sel;
  logic        iv_v, or_v, cin_v;
  logic [31:0] x_v, y_v;
  int          vectors;
  int          miscompares;
  logic [7:0]  cin_hist;

  logic        in_ready_o, out_valid_o, cout_o, ovf_o, busy_o, addcin_o;
  logic [31:0] result_o;
  logic [3:0]  adda_o, addb_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_word_adder_ctrl_if #(.NIBBLES(4)) if4 ();
  serial_word_adder_ctrl_if #(.NIBBLES(2)) if2 ();
  serial_word_adder_ctrl_if #(.NIBBLES(8)) if8 ();

  logic [3:0] a4, b4, s4, a2, b2, s2, a8, b8, s8;
  logic       ci4, co4, ci2, co2, ci8, co8;

  assign if4.InValid = iv_v && (sel == 0);
  assign if4.OutReady = or_v && (sel == 0);
  assign if4.X = x_v[15:0];
  assign if4.Y = y_v[15:0];
  assign if4.CinIn = cin_v;
  assign if2.InValid = iv_v && (sel == 1);
  assign if2.OutReady = or_v && (sel == 1);
  assign if2.X = x_v[7:0];
  assign if2.Y = y_v[7:0];
  assign if2.CinIn = cin_v;
  assign if8.InValid = iv_v && (sel == 2);
  assign if8.OutReady = or_v && (sel == 2);
  assign if8.X = x_v;
  assign if8.Y = y_v;
  assign if8.CinIn = cin_v;

  serial_word_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4),
    .AddA(a4), .AddB(b4), .AddCin(ci4), .AddSum(s4), .AddCout(co4));
  ripple_carry_adder4 add4 (.A(a4), .B(b4), .Cin(ci4), .Sum(s4), .Cout(co4));
  serial_word_adder_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2),
    .AddA(a2), .AddB(b2), .AddCin(ci2), .AddSum(s2), .AddCout(co2));
  ripple_carry_adder4 add2 (.A(a2), .B(b2), .Cin(ci2), .Sum(s2), .Cout(co2));
  serial_word_adder_ctrl #(.NIBBLES(8)) dut8 (.clk(clk), .rst(rst), .bus(if8),
    .AddA(a8), .AddB(b8), .AddCin(ci8), .AddSum(s8), .AddCout(co8));
  ripple_carry_adder4 add8 (.A(a8), .B(b8), .Cin(ci8), .Sum(s8), .Cout(co8));

  always_comb begin
    case (sel)
      1: begin
        in_ready_o = if2.InReady; out_valid_o = if2.OutValid; result_o = 32'(if2.Result);
        cout_o = if2.CoutOut; ovf_o = if2.Overflow; busy_o = if2.Busy;
        adda_o = a2; addb_o = b2; addcin_o = ci2;
      end
      2: begin
        in_ready_o = if8.InReady; out_valid_o = if8.OutValid; result_o = if8.Result;
        cout_o = if8.CoutOut; ovf_o = if8.Overflow; busy_o = if8.Busy;
        adda_o = a8; addb_o = b8; addcin_o = ci8;
      end
      default: begin
        in_ready_o = if4.InReady; out_valid_o = if4.OutValid; result_o = 32'(if4.Result);
        cout_o = if4.CoutOut; ovf_o = if4.Overflow; busy_o = if4.Busy;
        adda_o = a4; addb_o = b4; addcin_o = ci4;
      end
    endcase
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word sum straight from the arithmetic definition: {overflow, carry-out, result}.
  function automatic logic [33:0] ref_add(input int n, input logic [31:0] x, input logic [31:0] y,
                                          input logic cin);
    int          w;
    logic [63:0] mask, xs, ys, s;
    logic        co, ov;
    w    = 4 * n;
    mask = (64'd1 << w) - 64'd1;
    xs   = {32'd0, x} & mask;
    ys   = {32'd0, y} & mask;
    s    = xs + ys + {63'd0, cin};
    co   = s[w];
    ov   = (xs[w-1] == ys[w-1]) && (s[w-1] != xs[w-1]);
    return {ov, co, 32'(s & mask)};
  endfunction

  task automatic do_txn(input int n, input logic [31:0] x, input logic [31:0] y, input logic cin,
                        input logic [31:0] e_res, input logic e_cout, input logic e_ovf,
                        input int stall, input bit rnd_or, input bit poke,
                        input logic [31:0] px, input logic [31:0] py);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready_o && guard < 20) begin
      step();
      guard++;
    end
    chk("in_ready_wait", 32'(in_ready_o), 32'd1);
    x_v = x; y_v = y; cin_v = cin; iv_v = 1'b1; or_v = 1'b0;
    step();
    iv_v = 1'b0;
    lat = 1;
    cin_hist = 8'd0;
    while (!out_valid_o && lat < 40) begin
      if (lat <= 8) cin_hist[lat-1] = addcin_o;
      if (rnd_or) or_v = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(n + 1));
    chk("result", result_o, e_res);
    chk("cout", 32'(cout_o), 32'(e_cout));
    chk("overflow", 32'(ovf_o), 32'(e_ovf));
    for (int s = 0; s < stall; s++) begin
      or_v = 1'b0;
      if (poke) begin
        iv_v = 1'b1; x_v = px; y_v = py;
      end
      step();
      chk("hold_result", result_o, e_res);
      chk("hold_valid", 32'(out_valid_o), 32'd1);
      chk("hold_in_ready", 32'(in_ready_o), 32'd0);
      chk("done_adda", 32'(adda_o), 32'd0);
    end
    or_v = 1'b1;
    step();
    or_v = 1'b0;
    iv_v = 1'b0;
    chk("post_in_ready", 32'(in_ready_o), 32'd1);
    chk("post_valid", 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] rx, ry;
    logic        rc;
    vectors = 0; miscompares = 0;
    sel = 0; iv_v = 1'b0; or_v = 1'b0; cin_v = 1'b0; x_v = 32'd0; y_v = 32'd0;
    rst = 1'b1;

    tbl[0] = '{32'h1234, 32'h0FCD, 1'b0, 32'h2201, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1};
    tbl[3] = '{32'h0000, 32'h0000, 1'b1, 32'h0001, 1'b0, 1'b0};
    tbl[4] = '{32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1};
    tbl[5] = '{32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 1'b0};

    step(); step();
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_flags", {30'd0, cout_o, ovf_o}, 32'd0);
    chk("rst_add", {23'd0, adda_o, addb_o, addcin_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);

    for (int i = 0; i < 7; i++)
      do_txn(4, tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].res, tbl[i].cout, tbl[i].ovf,
             i % 3, 1'b0, 1'b0, 32'd0, 32'd0);

    // Carry ripple: only nibble 0 sees a zero carry-in.
    do_txn(4, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("ripple_cin", {28'd0, cin_hist[3:0]}, 32'h0000_000E);

    // Backpressure with a new operand pair offered during DONE.
    do_txn(4, 32'h1111, 32'h2222, 1'b0, 32'h3333, 1'b0, 1'b0, 3, 1'b0, 1'b1,
           32'hABCD, 32'h1234);
    do_txn(4, 32'hABCD, 32'h1234, 1'b0, 32'hBE01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of RUN, while nibble 2 is on the adder.
    x_v = 32'h5A5A; y_v = 32'h3C3C; cin_v = 1'b0; iv_v = 1'b1;
    step();
    iv_v = 1'b0;
    step(); step();
    chk("mid_run_adda", 32'(adda_o), 32'h0000_000A);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("mid_rst_add", {23'd0, adda_o, addb_o, addcin_o}, 32'd0);
    chk("mid_rst_result", result_o, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("after_rst_out_valid", 32'(out_valid_o), 32'd0);
    end
    do_txn(4, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 1'b0, 1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Randomized sweeps at the narrowest and widest word.
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0) ? 1 : 2;
      step();
      for (int t = 0; t < 500; t++) begin
        rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1));
        m = ref_add((sel == 1) ? 2 : 8, rx, ry, rc);
        do_txn((sel == 1) ? 2 : 8, rx, ry, rc, m[31:0], m[32], m[33],
               int'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
